// File: rtl/ds_adc_dec.sv
// ds_adc_dec: closes the loop of an external first-order delta-sigma modulator
// and decimates its bitstream with a 3rd-order CIC to signed OUT_W-bit samples.
module ds_adc_dec #(
  parameter int unsigned DEC         = 64,
  parameter int unsigned OUT_W       = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WARMUP      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cke,
  input  logic             comp_in,
  output logic             dac_drive,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);

  localparam int unsigned LOG2_DEC = $clog2(DEC);
  localparam int unsigned ACC_W    = 3 * LOG2_DEC + 2;
  localparam int unsigned SHIFT    = 3 * LOG2_DEC - (OUT_W - 1);
  localparam int unsigned WU_W     = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  // comparator synchronizer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
    end
  end

  assign comp_s = sync_q[SYNC_STAGES-1];

  // feedback bit, integrators and decimation counter, all paced by cke
  logic signed [ACC_W-1:0] x_c;
  logic signed [ACC_W-1:0] i1, i2, i3;
  logic [LOG2_DEC-1:0]     dcnt;
  logic                    dtick;

  // integrators consume the bit currently on the DAC, before this cke updates it
  assign x_c = dac_drive ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_drive <= 1'b0;
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      dcnt      <= '0;
      dtick     <= 1'b0;
    end else begin
      dtick <= cke && (dcnt == LOG2_DEC'(DEC - 1));
      if (cke) begin
        dac_drive <= comp_s;
        i1        <= i1 + x_c;
        i2        <= i2 + i1;
        i3        <= i3 + i2;
        dcnt      <= dcnt + LOG2_DEC'(1);
      end
    end
  end

  // comb chain at the decimated rate
  logic signed [ACC_W-1:0] i3_d, c1_d, c2_d, c3;
  logic signed [ACC_W-1:0] diff1_c, diff2_c, diff3_c;
  logic                    ctick;

  assign diff1_c = i3 - i3_d;
  assign diff2_c = diff1_c - c1_d;
  assign diff3_c = diff2_c - c2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i3_d  <= '0;
      c1_d  <= '0;
      c2_d  <= '0;
      c3    <= '0;
      ctick <= 1'b0;
    end else begin
      ctick <= dtick;
      if (dtick) begin
        i3_d <= i3;
        c1_d <= diff1_c;
        c2_d <= diff2_c;
        c3   <= diff3_c;
      end
    end
  end

  // scale to OUT_W bits; only the exact positive full scale can overflow
  logic signed [ACC_W-1:0] scaled_c;
  logic [OUT_W-1:0]        sat_c;

  assign scaled_c = c3 >>> SHIFT;

  always_comb begin
    sat_c = scaled_c[OUT_W-1:0];
    if (scaled_c > Y_MAX) begin
      sat_c = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (scaled_c < Y_MIN) begin
      sat_c = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // output register; valid held off until the filter history is fully populated
  logic [WU_W-1:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      wcnt       <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (ctick) begin
        dout <= sat_c;
        if (wcnt == WU_W'(WARMUP)) begin
          dout_valid <= 1'b1;
        end else begin
          wcnt <= wcnt + WU_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ds_adc_dec.sv
// tb_ds_adc_dec: table-driven and hand-sequenced checks of ds_adc_dec against
// a behavioural loop/timing model and a bench-side first-order modulator.
module tb_ds_adc_dec;

  localparam int unsigned DEC         = 64;
  localparam int unsigned OUT_W       = 10;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned WARMUP      = 3;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b1;
  logic             cke     = 1'b0;
  logic             comp_in = 1'b0;
  logic             dac_drive;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ds_adc_dec #(
    .DEC(DEC), .OUT_W(OUT_W), .SYNC_STAGES(SYNC_STAGES), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .comp_in(comp_in),
    .dac_drive(dac_drive), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // cke strobe generator: one clk wide, random gap in [gap_min, gap_max]
  int unsigned gap_min = 4, gap_max = 4;
  int          gap_left = 0;
  bit          cke_run = 1'b0;

  always @(negedge clk) begin
    if (cke_run && gap_left == 0) begin
      cke = 1'b1;
      gap_left = int'($urandom_range(gap_max, gap_min)) - 1;
    end else begin
      cke = 1'b0;
      if (gap_left > 0) gap_left--;
    end
  end

  // comparator stimulus: 0 manual, 1 const high, 2 const low, 3 alternate, 4 modulator
  int     mode  = 0;
  int     level = 0;
  longint v     = 0;

  always @(posedge clk) begin
    if (cke && rst_n) begin
      #1;
      case (mode)
        1: comp_in = 1'b1;
        2: comp_in = 1'b0;
        3: comp_in = ~dac_drive;
        4: begin
          v = v + longint'(level) * 64 - (dac_drive ? 64'sd32768 : -64'sd32768);
          comp_in = (v >= 0);
        end
        default: ;
      endcase
    end
  end

  // behavioural model: DAC bit = comparator seen SYNC_STAGES edges before the cke,
  // valid pulse 2 clk after every DEC-th cke once WARMUP frames have passed
  logic             hist [SYNC_STAGES];
  logic             exp_dac;
  int               cke_cnt, dec_cnt;
  bit               vp0, vp1;
  longint           cyc = 0;
  logic [OUT_W-1:0] vq [$];
  longint           tq [$];
  int               cq [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) hist[i] = 1'b0;
      exp_dac = 1'b0;
      cke_cnt = 0;
      dec_cnt = 0;
      vp0 = 1'b0;
      vp1 = 1'b0;
    end else begin : model
      bit exp_v;
      cyc++;
      exp_v = vp1;
      vp1 = vp0;
      vp0 = 1'b0;
      if (cke) begin
        exp_dac = hist[SYNC_STAGES-1];
        if (cke_cnt % DEC == DEC - 1) begin
          dec_cnt++;
          vp0 = (dec_cnt > int'(WARMUP));
        end
        cke_cnt++;
      end
      for (int i = int'(SYNC_STAGES) - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = comp_in;
      #1;
      check("dac_drive", int'(dac_drive), int'(exp_dac), int'(exp_dac));
      check("dout_valid", int'(dout_valid), int'(exp_v), int'(exp_v));
      if (dout_valid) begin
        vq.push_back(dout);
        tq.push_back(cyc);
        cq.push_back(cke_cnt);
      end
    end
  end

  task automatic do_reset();
    cke_run = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dac", int'(dac_drive), 0, 0);
    check("rst_dout", int'($signed(dout)), 0, 0);
    check("rst_valid", int'(dout_valid), 0, 0);
    v = 0;
    repeat (2) @(negedge clk);
    vq.delete();
    tq.delete();
    cq.delete();
    rst_n = 1'b1;
    cke_run = 1'b1;
  endtask

  task automatic wait_valids(input int n, input int budget, input string name);
    int k = 0;
    while (vq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (vq.size() < n) check({name, "_timeout"}, vq.size(), n, n);
  endtask

  task automatic wait_cke(input int budget);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!cke && k < budget);
    if (!cke) check("cke_timeout", 0, 1, 1);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    level;
    int    gmin;
    int    gmax;
    int    lo;
    int    hi;
  } vec_t;

  vec_t vt [10];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r;
    int n0;
    logic d0;
    r = int'($urandom_range(800)) - 400;
    vt[0] = '{"pos_fs",      1, 0,    4, 4, 511,   511};
    vt[1] = '{"neg_fs",      2, 0,    4, 4, -512,  -512};
    vt[2] = '{"zero_alt",    3, 0,    4, 4, 0,     0};
    vt[3] = '{"cl_p200",     4, 200,  4, 4, 198,   202};
    vt[4] = '{"cl_m300",     4, -300, 4, 4, -302,  -298};
    vt[5] = '{"pos_fs_rgap", 1, 0,    3, 7, 511,   511};
    vt[6] = '{"zero_rgap",   3, 0,    3, 7, 0,     0};
    vt[7] = '{"cl_random",   4, r,    3, 6, r - 2, r + 2};
    vt[8] = '{"neg_fs_b2b",  2, 0,    1, 1, -512,  -512};
    vt[9] = '{"pos_fs_fast", 1, 0,    1, 2, 511,   511};

    for (int i = 0; i < 10; i++) begin
      mode    = vt[i].mode;
      level   = vt[i].level;
      gap_min = vt[i].gmin;
      gap_max = vt[i].gmax;
      comp_in = (vt[i].mode == 1);
      do_reset();
      wait_valids(4, 8000, vt[i].name);
      for (int j = 0; j < vq.size(); j++)
        check(vt[i].name, int'($signed(vq[j])), vt[i].lo, vt[i].hi);
      if (vt[i].gmin == 4 && vt[i].gmax == 4 && tq.size() >= 2)
        check({vt[i].name, "_spacing"}, int'(tq[1] - tq[0]), 4 * DEC, 4 * DEC);
    end

    // mid-frame async reset restarts the frame and the warm-up
    mode = 1; gap_min = 4; gap_max = 4; comp_in = 1'b1;
    do_reset();
    wait_valids(1, 6000, "midrst_pre");
    repeat (100) @(posedge clk);
    do_reset();
    wait_valids(1, 6000, "midrst_post");
    if (cq.size() >= 1) begin
      check("warmup_cke_count", cq[0], 4 * DEC, 4 * DEC);
      check("warmup_first_dout", int'($signed(vq[0])), 511, 511);
    end

    // comparator edge one clk before a cke is only seen at the following cke
    mode = 0; comp_in = 1'b0;
    do_reset();
    wait_cke(20);
    repeat (3) @(posedge clk);
    #1 comp_in = 1'b1;
    @(posedge clk);
    #1 check("sync_hold", int'(dac_drive), 0, 0);
    repeat (4) @(posedge clk);
    #1 check("sync_set", int'(dac_drive), 1, 1);

    // cke stall freezes the loop and the decimation phase
    mode = 1;
    wait_valids(1, 6000, "stall_pre");
    repeat (20) @(posedge clk);
    cke_run = 1'b0;
    mode = 0;
    comp_in = 1'b0;
    n0 = vq.size();
    d0 = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("stall_dac", int'(dac_drive), int'(d0), int'(d0));
    check("stall_no_valid", vq.size(), n0, n0);
    cke_run = 1'b1;
    wait_valids(n0 + 1, 2000, "stall_post");
    if (cq.size() > n0 && n0 >= 1)
      check("stall_dcnt", cq[n0] - cq[n0-1], DEC, DEC);

    // closed-loop step 200 -> -300 settles within three decimated samples
    mode = 4; level = 200; gap_min = 4; gap_max = 4; comp_in = 1'b0;
    do_reset();
    wait_valids(3, 6000, "step_pre");
    if (vq.size() >= 3) check("step_before", int'($signed(vq[2])), 198, 202);
    level = -300;
    wait_valids(7, 3000, "step_post");
    if (vq.size() >= 7) begin
      check("step_settle3", int'($signed(vq[5])), -302, -298);
      check("step_settle4", int'($signed(vq[6])), -302, -298);
    end

    cke_run = 1'b0;
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
